// File: rtl/audio_pkg.sv
// Shared types for the audio output arbiter: sample width, stereo sample struct, FSM states
// and the clamp limits used when mixing (AUD_MIX_EN builds).
package audio_pkg;

    localparam int SAMPLE_W = 24;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef struct packed {
        sample_t left;
        sample_t right;
    } stereo_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } arb_state_t;

    localparam sample_t SAMPLE_MAX = 24'sh7FFFFF;
    localparam sample_t SAMPLE_MIN = -24'sh800000;

endpackage

// File: rtl/sat_add24.sv
// Combinational signed saturating adder for one audio channel.
// Only compiled when AUD_MIX_EN is defined, so non-mixing builds carry no adder.
`ifdef AUD_MIX_EN
module sat_add24
    import audio_pkg::*;
(
    input  sample_t a_i,
    input  sample_t b_i,
    output sample_t sum_o
);

    logic [SAMPLE_W:0] wide;

    // One guard bit: overflow shows up as the two top bits disagreeing.
    always_comb begin
        wide = {a_i[SAMPLE_W-1], a_i} + {b_i[SAMPLE_W-1], b_i};
        if (wide[SAMPLE_W] != wide[SAMPLE_W-1]) begin
            sum_o = wide[SAMPLE_W] ? SAMPLE_MIN : SAMPLE_MAX;
        end else begin
            sum_o = sample_t'(wide[SAMPLE_W-1:0]);
        end
    end

endmodule
`endif

// File: rtl/audio_out_arbiter.sv
// Arbitrates a music source and an effects source onto the codec DAC write port.
// Define AUD_MIX_EN to mix simultaneous samples (saturating sum) instead of round-robin.
module audio_out_arbiter
    import audio_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    input  logic                 src0_valid,
    input  sample_t              src0_left,
    input  sample_t              src0_right,
    output logic                 src0_ready,
    input  logic                 src1_valid,
    input  sample_t              src1_left,
    input  sample_t              src1_right,
    output logic                 src1_ready,
    input  logic                 write_ready,
    output logic                 write,
    output sample_t              writedata_left,
    output sample_t              writedata_right,
    output logic [1:0]           active_src,
    output logic [CNT_W-1:0]     underrun_cnt
);

    arb_state_t       state_q;
    stereo_t          sample_q;
    stereo_t          sample_d;
    logic [1:0]       active_q;
    logic [CNT_W-1:0] underrun_q;
    logic             last_grant_q;
    logic             grant0;
    logic             grant1;
    logic             take;

`ifdef AUD_MIX_EN
    stereo_t mix_data;

    sat_add24 u_add_left (
        .a_i   (src0_left),
        .b_i   (src1_left),
        .sum_o (mix_data.left)
    );

    sat_add24 u_add_right (
        .a_i   (src0_right),
        .b_i   (src1_right),
        .sum_o (mix_data.right)
    );
`endif

    // last_grant_q = 1 means src1 was granted last, so src0 wins the next tie.
    always_comb begin
        grant0   = 1'b0;
        grant1   = 1'b0;
        sample_d = '0;
        if (src0_valid && src1_valid) begin
`ifdef AUD_MIX_EN
            grant0   = 1'b1;
            grant1   = 1'b1;
            sample_d = mix_data;
`else
            grant0   = last_grant_q;
            grant1   = ~last_grant_q;
            sample_d = last_grant_q ? stereo_t'{src0_left, src0_right}
                                    : stereo_t'{src1_left, src1_right};
`endif
        end else if (src0_valid) begin
            grant0   = 1'b1;
            sample_d = stereo_t'{src0_left, src0_right};
        end else if (src1_valid) begin
            grant1   = 1'b1;
            sample_d = stereo_t'{src1_left, src1_right};
        end
    end

    // Gating with reset keeps a pending sample from being written or re-requested.
    assign take       = reset && (state_q == IDLE) && write_ready;
    assign src0_ready = take && grant0;
    assign src1_ready = take && grant1;
    assign write      = reset && (state_q == ISSUE) && write_ready;

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            state_q      <= IDLE;
            sample_q     <= '0;
            active_q     <= 2'b00;
            underrun_q   <= '0;
            last_grant_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (write_ready) begin
                        sample_q <= sample_d;
                        active_q <= {grant1, grant0};
                        if (!grant0 && !grant1 && (underrun_q != {CNT_W{1'b1}})) begin
                            underrun_q <= underrun_q + 1'b1;
                        end
                        if (grant0 ^ grant1) begin
                            last_grant_q <= grant1;
                        end
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (write_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign writedata_left  = sample_q.left;
    assign writedata_right = sample_q.right;
    assign active_src      = active_q;
    assign underrun_cnt    = underrun_q;

endmodule
